// File: rtl/alu_pkg.sv
// Definitions shared by alu_top and its response consumers: op encodings,
// the decoded-record layout and the 8-bit signed range limits.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  localparam logic signed [15:0] S8_MIN = -16'sd128;
  localparam logic signed [15:0] S8_MAX = 16'sd127;

  typedef struct packed {
    op_t         op;
    logic [15:0] value;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        dbz;
  } rec_t;

  function automatic logic out_of_s8(input logic signed [15:0] v);
    return (v < S8_MIN) || (v > S8_MAX);
  endfunction

endpackage

// File: rtl/alu_resp_unpack.sv
// Combinational decode of one alu_top response into a record; every field
// not meaningful for the op is forced to zero.
module alu_resp_unpack
  import alu_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] result,
  output rec_t        rec
);

  logic signed [8:0] diff;

  always_comb begin
    rec    = '0;
    rec.op = op_t'(op);
    diff   = $signed({a[7], a}) - $signed({b[7], b});
    case (op_t'(op))
      OP_ADD: begin
        rec.value = result;
        rec.ovf   = out_of_s8(result);
      end
      // alu_top only returns the wrapped low byte for sub, so overflow is
      // judged from the operands themselves.
      OP_SUB: begin
        rec.value = {{8{result[7]}}, result[7:0]};
        rec.ovf   = out_of_s8({{7{diff[8]}}, diff});
      end
      OP_MUL: begin
        rec.value = result;
      end
      default: begin
        rec.dbz = (b == 8'd0);
        if (!rec.dbz) begin
          rec.quot  = result[15:8];
          rec.rem   = result[7:0];
          rec.value = {{8{result[15]}}, result[15:8]};
        end
      end
    endcase
    rec.zero = (rec.value == 16'd0);
    rec.neg  = rec.value[15];
  end

endmodule

// File: rtl/alu_resp_decoder.sv
// Accepts alu_top responses, decodes them and queues the records in a small
// FIFO toward the consumer, with saturating accept/divide-by-zero counters.
module alu_resp_decoder
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [15:0]      in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [15:0]      out_value,
  output logic [7:0]       out_quot,
  output logic [7:0]       out_rem,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_dbz,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_dbz
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rec_t             dec;
  rec_t             head;
  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_total_reg;
  logic [CNT_W-1:0] cnt_dbz_reg;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  alu_resp_unpack u_unpack (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (in_result),
    .rec    (dec)
  );

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cnt_total_reg <= '0;
      cnt_dbz_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (cnt_total_reg != CNT_MAX) begin
          cnt_total_reg <= cnt_total_reg + CNT_W'(1);
        end
        if (dec.dbz && (cnt_dbz_reg != CNT_MAX)) begin
          cnt_dbz_reg <= cnt_dbz_reg + CNT_W'(1);
        end
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Memory is never reset; gating on empty keeps stale entries off the outputs.
  assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  assign out_op    = head.op;
  assign out_value = head.value;
  assign out_quot  = head.quot;
  assign out_rem   = head.rem;
  assign out_zero  = head.zero;
  assign out_neg   = head.neg;
  assign out_ovf   = head.ovf;
  assign out_dbz   = head.dbz;
  assign cnt_total = cnt_total_reg;
  assign cnt_dbz   = cnt_dbz_reg;

endmodule

// File: tb/tb_alu_resp_decoder.sv
// Self-checking bench: directed and random responses compared each cycle
// against a queue-based model of decoded records and saturating counters.
module tb_alu_resp_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = '0;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic [15:0]      in_result = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_op;
  logic [15:0]      out_value;
  logic [7:0]       out_quot;
  logic [7:0]       out_rem;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;
  logic             out_dbz;
  logic [CNT_W-1:0] cnt_total;
  logic [CNT_W-1:0] cnt_dbz;

  alu_resp_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_value (out_value),
    .out_quot  (out_quot),
    .out_rem   (out_rem),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf),
    .out_dbz   (out_dbz),
    .cnt_total (cnt_total),
    .cnt_dbz   (cnt_dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] value;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t model_q[$];
  int   model_total = 0;
  int   model_dbz   = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decode from the arithmetic meaning of each op, using plain integers.
  function automatic exp_t model_decode(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [15:0] r);
    exp_t e;
    int av, bv, v, q, m;
    av = $signed(a);
    bv = $signed(b);
    v = 0; q = 0; m = 0;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    case (op)
      2'd0: begin v = $signed(r); e.ovf = (v < -128) || (v > 127); end
      2'd1: begin v = $signed(r[7:0]); e.ovf = ((av - bv) < -128) || ((av - bv) > 127); end
      2'd2: v = $signed(r);
      default: begin
        if (bv == 0) e.dbz = 1'b1;
        else begin q = $signed(r[15:8]); m = $signed(r[7:0]); v = q; end
      end
    endcase
    e.op    = op;
    e.value = 16'(v);
    e.quot  = 8'(q);
    e.rem   = 8'(m);
    e.zero  = (v == 0);
    e.neg   = (v < 0);
    return e;
  endfunction

  task automatic compare_all();
    exp_t h;
    h = '{op: 2'd0, value: 16'd0, quot: 8'd0, rem: 8'd0, zero: 1'b0, neg: 1'b0, ovf: 1'b0, dbz: 1'b0};
    if (model_q.size() > 0) h = model_q[0];
    check("in_ready",  32'(in_ready),  32'(model_q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    check("out_op",    32'(out_op),    32'(h.op));
    check("out_value", 32'(out_value), 32'(h.value));
    check("out_quot",  32'(out_quot),  32'(h.quot));
    check("out_rem",   32'(out_rem),   32'(h.rem));
    check("out_zero",  32'(out_zero),  32'(h.zero));
    check("out_neg",   32'(out_neg),   32'(h.neg));
    check("out_ovf",   32'(out_ovf),   32'(h.ovf));
    check("out_dbz",   32'(out_dbz),   32'(h.dbz));
    check("cnt_total", 32'(cnt_total), 32'(model_total));
    check("cnt_dbz",   32'(cnt_dbz),   32'(model_dbz));
  endtask

  // One clock: check the settled state, drive inputs, advance model at the edge.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] r, input logic rdy);
    exp_t e;
    logic acc, pp;
    @(negedge clk);
    compare_all();
    in_valid = v; in_op = op; in_a = a; in_b = b; in_result = r; out_ready = rdy;
    acc = v && (model_q.size() < DEPTH);
    pp  = rdy && (model_q.size() > 0);
    e   = model_decode(op, a, b, r);
    @(posedge clk);
    if (pp) begin
      $display("pop  op=%0d value=0x%04h", model_q[0].op, model_q[0].value);
      void'(model_q.pop_front());
    end
    if (acc) begin
      $display("push op=%0d a=%0d b=%0d result=0x%04h", op, $signed(a), $signed(b), r);
      model_q.push_back(e);
      if (model_total < CNT_MAX) model_total++;
      if (e.dbz && model_dbz < CNT_MAX) model_dbz++;
    end
  endtask

  initial begin
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic [15:0] r;
    int sum;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed decode cases
    cycle(1'b1, 2'b00, 8'd100, 8'd5, 16'd105, 1'b1);
    cycle(1'b1, 2'b01, 8'h9C, 8'd5, 16'h0097, 1'b1);
    cycle(1'b1, 2'b01, 8'h9C, 8'd50, 16'h006A, 1'b1);
    cycle(1'b1, 2'b11, 8'h9C, 8'd5, 16'hEC00, 1'b1);
    cycle(1'b1, 2'b11, 8'd50, 8'd0, 16'h0000, 1'b1);
    cycle(1'b1, 2'b10, 8'd10, 8'd3, 16'd30, 1'b1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b1);

    // Reset counters, then fill past capacity with the consumer stalled
    @(negedge clk); rst = 1'b1; model_q.delete(); model_total = 0; model_dbz = 0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b1, 2'b10, 8'(i + 1), 8'd2, 16'(2 * (i + 1)), 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b1);
    cycle(1'b1, 2'b00, 8'd1, 8'd1, 16'd2, 1'b0);
    cycle(1'b1, 2'b00, 8'd2, 8'd2, 16'd4, 1'b0);
    cycle(1'b1, 2'b00, 8'd3, 8'd3, 16'd6, 1'b1);
    cycle(1'b1, 2'b00, 8'd4, 8'd4, 16'd8, 1'b1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b0);

    // Asynchronous reset with records queued
    cycle(1'b1, 2'b11, 8'd7, 8'd0, 16'h1234, 1'b0);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_q.delete(); model_total = 0; model_dbz = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cnt_total", 32'(cnt_total), 32'd0);
    check("rst_cnt_dbz",   32'(cnt_dbz),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk); rst = 1'b0;
    cycle(1'b1, 2'b10, 8'hFD, 8'd4, 16'hFFF4, 1'b0);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b1);
    cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b0);

    // Random traffic; counters saturate along the way
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      r  = 16'($urandom);
      if (op == 2'd0 && $urandom_range(0, 1) == 1) begin
        sum = $signed(a) + $signed(b);
        r = 16'(sum);
      end
      cycle(($urandom_range(0, 9) < 7), op, a, b, r, ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b0, 2'b00, 8'd0, 8'd0, 16'd0, 1'b1);
    @(negedge clk);
    compare_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_resp_decoder.md
Name: alu_resp_decoder

Overview:
Consumer-side block for alu_top responses: accepts a transaction {op, A, B, result} over valid/ready and unpacks the packed 16-bit result into per-operation fields. Fields are the normalized value, quotient and remainder, and status flags. Decoded records are buffered in a small FIFO toward the downstream consumer (register file or host readback). Saturating statistics counters are kept alongside.

Parameters:
DEPTH, 4, output FIFO entries (power of two, >=2)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  response transaction valid
in_ready  out  1  block can accept (FIFO not full)
in_op  in  2  00 add, 01 sub, 10 mul, 11 div
in_a  in  8  signed operand A as issued
in_b  in  8  signed operand B as issued
in_result  in  16  raw alu_top result
out_valid  out  1  decoded record available (FIFO not empty)
out_ready  in  1  consumer accepts record
out_op  out  2  op of head record
out_value  out  16  signed normalized value
out_quot  out  8  signed quotient (div only, else 0)
out_rem  out  8  signed remainder (div only, else 0)
out_zero  out  1  out_value == 0
out_neg  out  1  out_value[15]
out_ovf  out  1  true result does not fit 8-bit signed (add/sub only)
out_dbz  out  1  divide by zero (div only)
cnt_total  out  CNT_W  records accepted, saturating
cnt_dbz  out  CNT_W  divide-by-zero records accepted, saturating

Behaviour:
- Reset (async, active-high): FIFO empty, pointers 0, out_valid=0, in_ready=1, cnt_* =0. Head data outputs are 0 while the FIFO is empty.
- Accept: in_valid & in_ready at a rising edge. The decode is combinational on the inputs and is written into the FIFO in the same edge. out_valid rises the next cycle, giving 1-cycle latency from an empty FIFO.
- Decode, add (00): value=in_result. ovf = value outside [-128,127].
- Decode, sub (01): alu_top returns only the low 8 bits. value = sign-extend(in_result[7:0]). ovf = 9-bit signed (A-B) outside [-128,127].
- Decode, mul (10): value=in_result. ovf=0.
- Decode, div (11): quot=in_result[15:8], rem=in_result[7:0], value=sign-extend(quot). dbz=(in_b==0). When dbz=1: quot=rem=value=0, regardless of in_result.
- For non-div ops: quot=rem=0 and dbz=0. For all ops: zero and neg are derived from the final value.
- Pop: out_valid & out_ready at a rising edge advances the read pointer.
- Full: in_ready=0. Any in_valid is ignored and nothing is counted.
- Simultaneous push and pop when full: not allowed. in_ready is strictly !full, with no bypass.
- Simultaneous push and pop otherwise: both take effect, occupancy unchanged.
- Empty: out_valid=0. out_ready is ignored.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full/empty come from the MSB compare.
- Counters: cnt_total increments on each accept. cnt_dbz increments on each accepted dbz record. Both hold at 2^CNT_W-1.
- Reset mid-operation: FIFO contents and counters are discarded immediately. out_valid drops asynchronously.

Decomposition:
- Shared package alu_pkg: op encodings (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11), a decoded-record struct {op, value, quot, rem, zero, neg, ovf, dbz}, and S8_MIN/S8_MAX constants. alu_top is to be migrated to the same op constants.
- Sub-module alu_resp_unpack: purely combinational decode of one transaction into the record.
- The top level holds the FIFO and the counters.

Test Plan:
- Reset, then push add A=100 B=5 result=16'd105 -> next cycle out_valid=1, value=105, ovf=0, zero=0, neg=0. cnt_total=1.
- Push sub A=-100 B=5 result=16'h0097 -> value=16'hFF97 (-105), neg=1, ovf=0. Then push sub A=-100 B=50 result=16'h006A -> value=106, ovf=1.
- Push div A=-100 B=5 result={8'hEC,8'h00} -> quot=-20, rem=0, value=16'hFFEC, dbz=0. Then push div A=50 B=0 result=0 -> dbz=1, zero=1, cnt_dbz=1.
- Push mul A=10 B=3 result=16'd30 -> value=30, ovf=0, quot=rem=0.
- Hold out_ready=0 and push DEPTH records -> in_ready=0 after the 4th. A 5th in_valid is ignored and cnt_total=4. Drain in order, then simultaneous push+pop with occupancy 2 -> occupancy stays 2.
- Assert rst while 3 records are queued -> out_valid=0 and counters=0 immediately. The first push after deassert is dequeued correctly.
